rst_seq_ctrl: RTL and testbench

- Reset sequencer for the CRG. Generates NUM_DOMAINS active-low asynchronous reset outputs from a single global reset and releases them in a fixed order, domain 0 first, with DELAY_CYCLES ref-clock cycles between releases.
- Per-domain software reset requests re-assert the requested domain and every higher-indexed (dependent) domain, then re-run the ordered release from that domain.
- Sits between the global reset pin and the per-domain reset consumers.

---
 rtl/rst_seq_ctrl.sv | 107 ++++++++++
 tb/tb_rst_seq_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises the global reset and releases per-domain
// active-low resets in index order, DELAY_CYCLES ref clocks apart.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS  = 4,
  parameter int DELAY_CYCLES = 128
) (
  input  logic                           ref_clk_i,
  input  logic                           glob_arst_n_i,
  input  logic [NUM_DOMAINS-1:0]         arst_req_i,
  output logic [NUM_DOMAINS-1:0]         arst_n_o,
  output logic                           seq_done_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_DOMAINS)-1:0] rel_idx_o
);

  localparam int IW = $clog2(NUM_DOMAINS);
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

  localparam logic [0:0] ST_COUNT = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [1:0]             sync;
  logic                   rst_s;
  logic [NUM_DOMAINS-1:0] r, r_nxt;
  logic [IW-1:0]          rel_idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [0:0]             state, st_nxt;
  logic [IW-1:0]          m;
  logic                   req_any;
  logic [NUM_DOMAINS-1:0] clr_mask;

  // Asserts asynchronously, deasserts two ref clocks after the pin rises.
  always_ff @(posedge ref_clk_i or negedge glob_arst_n_i) begin
    if (!glob_arst_n_i) sync <= 2'b00;
    else                sync <= {sync[0], 1'b1};
  end
  assign rst_s = sync[1];

  assign req_any = |arst_req_i;

  always_comb begin
    m = '0;
    for (int j = NUM_DOMAINS - 1; j >= 0; j--) begin
      if (arst_req_i[j]) m = IW'(j);
    end
  end

  // A request also pulls down every higher-indexed dependent domain.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    clr_mask = '0;
    for (int j = 0; j < NUM_DOMAINS; j++) begin
      acc         = acc | arst_req_i[j];
      clr_mask[j] = acc;
    end
  end

  always_comb begin
    r_nxt   = r;
    idx_nxt = rel_idx;
    cnt_nxt = cnt;
    st_nxt  = state;
    if (state == ST_COUNT) begin
      if (cnt == CNT_LAST) begin
        r_nxt[rel_idx] = 1'b1;
        cnt_nxt        = '0;
        if (rel_idx == IDX_LAST) st_nxt  = ST_DONE;
        else                     idx_nxt = rel_idx + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      cnt_nxt = '0;
    end
    // A request at or below the current stage restarts from m and holds the
    // counter; the clear mask below also cancels any release on this edge.
    if (req_any && ((m <= rel_idx) || (state == ST_DONE))) begin
      idx_nxt = m;
      cnt_nxt = '0;
      st_nxt  = ST_COUNT;
    end
    r_nxt = r_nxt & ~clr_mask;
  end

  always_ff @(posedge ref_clk_i or negedge rst_s) begin
    if (!rst_s) begin
      r       <= '0;
      rel_idx <= '0;
      cnt     <= '0;
      state   <= ST_COUNT;
    end else begin
      r       <= r_nxt;
      rel_idx <= idx_nxt;
      cnt     <= cnt_nxt;
      state   <= st_nxt;
    end
  end

  assign arst_n_o   = r;
  assign seq_done_o = (state == ST_DONE);
  assign busy_o     = (state != ST_DONE);
  assign rel_idx_o  = rel_idx;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NUM_DOMAINS=4, DELAY_CYCLES=8.
module tb_rst_seq_ctrl;

  localparam int ND = 4;
  localparam int DC = 8;

  logic          clk;
  logic          clk_en;
  logic          glob_n;
  logic [ND-1:0] req;
  logic [ND-1:0] arst_n;
  logic          done;
  logic          busy;
  logic [1:0]    rel_idx;

  int tests_run;
  int tests_failed;

  rst_seq_ctrl #(.NUM_DOMAINS(ND), .DELAY_CYCLES(DC)) dut (
    .ref_clk_i     (clk),
    .glob_arst_n_i (glob_n),
    .arst_req_i    (req),
    .arst_n_o      (arst_n),
    .seq_done_o    (done),
    .busy_o        (busy),
    .rel_idx_o     (rel_idx)
  );

  // clock / reset
  initial begin
    clk    = 1'b0;
    clk_en = 1'b1;
  end
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step 1ns past the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] exp_arst, input logic exp_done,
                               input logic [1:0] exp_idx);
    check_eq({tag, "_arst"}, 32'(arst_n), 32'(exp_arst));
    check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    check_eq({tag, "_busy"}, 32'(busy), 32'(!exp_done));
    check_eq({tag, "_idx"}, 32'(rel_idx), 32'(exp_idx));
  endtask

  // Called just after the reference edge X; domain k releases at X + DC*(k-first+1).
  task automatic run_release(input string tag, input logic [3:0] start_pat, input int first);
    logic [3:0] pat;
    pat = start_pat;
    for (int k = first; k < ND; k++) begin
      wait_edges(DC - 1);
      check_eq({tag, "_pre"}, 32'(arst_n), 32'(pat));
      wait_edges(1);
      pat = pat | (4'b0001 << k);
      check_outputs({tag, "_rel"}, pat, (k == ND - 1), 2'((k == ND - 1) ? k : k + 1));
    end
  endtask

  task automatic pulse_req(input logic [3:0] val);
    req = val;
    wait_edges(1);
    req = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    glob_n       = 1'b0;
    req          = '0;

    // power-up
    repeat (10) @(posedge clk);
    #1;
    check_outputs("por_hold", 4'b0000, 1'b0, 2'd0);
    glob_n = 1'b1;
    wait_edges(2);
    check_outputs("por_e", 4'b0000, 1'b0, 2'd0);
    run_release("por", 4'b0000, 0);

    // request domain 2 from DONE
    pulse_req(4'b0100);
    check_outputs("req2", 4'b0011, 1'b0, 2'd2);
    run_release("req2", 4'b0011, 2);

    // multi-bit request, lowest bit (1) wins
    pulse_req(4'b1010);
    check_outputs("req13", 4'b0001, 1'b0, 2'd1);
    run_release("req13", 4'b0001, 1);

    // mid-sequence request of domain 0 with cnt=5 at rel_idx=2
    pulse_req(4'b0100);
    check_outputs("mid_a", 4'b0011, 1'b0, 2'd2);
    wait_edges(5);
    pulse_req(4'b0001);
    check_outputs("req0", 4'b0000, 1'b0, 2'd0);
    run_release("req0", 4'b0000, 0);

    // global reset with the clock stopped, mid-sequence
    pulse_req(4'b0100);
    wait_edges(3);
    check_eq("stop_pre", 32'(arst_n), 32'(4'b0011));
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    glob_n = 1'b0;
    #1;
    check_outputs("stop_async", 4'b0000, 1'b0, 2'd0);
    #30;
    clk_en = 1'b1;
    wait_edges(3);
    check_outputs("stop_hold", 4'b0000, 1'b0, 2'd0);
    glob_n = 1'b1;
    wait_edges(2);
    run_release("repor", 4'b0000, 0);

    // upper-domain request held while lower domain counts
    glob_n = 1'b0;
    wait_edges(2);
    glob_n = 1'b1;
    wait_edges(2);
    wait_edges(3);
    req = 4'b0010;
    wait_edges(5);
    check_outputs("hold_d0", 4'b0001, 1'b0, 2'd1);
    wait_edges(15);
    check_eq("hold_r", 32'(arst_n), 32'(4'b0001));
    req = '0;
    run_release("hold", 4'b0001, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
